// File: rtl/iir_cfg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iir_cfg_ctrl: shadow/active coefficient bank controller for the 7-biquad  |
// | IIR; optional readback port under IIR_CFG_READBACK_EN. Rev 1.0            |
// +----------------------------------------------------------------------------+
module iir_cfg_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [5:0]   wr_addr,
    input  logic [15:0]  wr_data,
    input  logic         commit_req,
    output logic [559:0] coef_o,
    output logic [3:0]   order_o,
    output logic         filt_rst_n,
    output logic         busy,
    output logic         done,
    output logic         err
`ifdef IIR_CFG_READBACK_EN
    ,
    input  logic [5:0]   rd_addr,
    output logic [15:0]  rd_data
`endif
);

    localparam int         NUM_SLOTS  = 35;
    localparam logic [5:0] ORDER_ADDR = 6'd35;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  flush_cnt;
    logic [15:0] shadow [NUM_SLOTS];
    logic [15:0] active [NUM_SLOTS];
    logic [3:0]  shadow_order;

    logic        wr_accept;
    logic        wr_coef;
    logic        wr_order;
    logic        wr_unmapped;
    logic [3:0]  order_eff;
    logic        order_ok;
    logic        commit_ok;
    logic        commit_bad;
    logic        copy_now;

    assign wr_ready    = reset && (state == IDLE);
    assign wr_accept   = wr_valid && (state == IDLE);
    assign wr_coef     = wr_accept && (wr_addr < ORDER_ADDR);
    assign wr_order    = wr_accept && (wr_addr == ORDER_ADDR);
    assign wr_unmapped = wr_accept && (wr_addr > ORDER_ADDR);

    // A same-cycle order write must be seen by the commit validation.
    assign order_eff = wr_order ? wr_data[3:0] : shadow_order;
    assign order_ok  = (order_eff != 4'd0) && (order_eff != 4'd15);
    assign copy_now  = (state == FLUSH) && (flush_cnt == 4'd0);

    always_comb begin
        next_state = state;
        commit_ok  = 1'b0;
        commit_bad = 1'b0;
        case (state)
            IDLE: begin
                if (commit_req) begin
                    if (order_ok) begin
                        next_state = FLUSH;
                        commit_ok  = 1'b1;
                    end else begin
                        commit_bad = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt == 4'd0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            flush_cnt <= 4'd0;
        end else begin
            state <= next_state;
            if (commit_ok) begin
                flush_cnt <= FLUSH_LOAD;
            end else if ((state == FLUSH) && (flush_cnt != 4'd0)) begin
                flush_cnt <= flush_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                shadow[k] <= 16'd0;
            end
            shadow_order <= 4'd0;
        end else begin
            if (wr_coef) begin
                shadow[wr_addr] <= wr_data;
            end
            if (wr_order) begin
                shadow_order <= wr_data[3:0];
            end
        end
    end

    // The active bank only ever changes on the FLUSH->DONE edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                active[k] <= 16'd0;
            end
            order_o <= 4'd0;
        end else if (copy_now) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                active[k] <= shadow[k];
            end
            order_o <= shadow_order;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            filt_rst_n <= 1'b0;
        end else begin
            busy       <= (next_state != IDLE);
            done       <= (next_state == DONE);
            err        <= commit_bad || wr_unmapped;
            filt_rst_n <= (next_state == DONE) ||
                          ((next_state == IDLE) && (order_o != 4'd0));
        end
    end

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_pack
        assign coef_o[16*k +: 16] = active[k];
    end

`ifdef IIR_CFG_READBACK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= 16'd0;
        end else if (rd_addr < ORDER_ADDR) begin
            rd_data <= shadow[rd_addr];
        end else if (rd_addr == ORDER_ADDR) begin
            rd_data <= {12'd0, shadow_order};
        end else begin
            rd_data <= 16'd0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_iir_cfg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_iir_cfg_ctrl: scoreboard bench for iir_cfg_ctrl. Rev 1.0               |
// +----------------------------------------------------------------------------+
module tb_iir_cfg_ctrl;

    localparam int F = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [5:0]   wr_addr = 6'd0;
    logic [15:0]  wr_data = 16'd0;
    logic         commit_req = 1'b0;
    logic [559:0] coef_o;
    logic [3:0]   order_o;
    logic         filt_rst_n;
    logic         busy;
    logic         done;
    logic         err;
`ifdef IIR_CFG_READBACK_EN
    logic [5:0]   rd_addr = 6'd0;
    logic [15:0]  rd_data;
`endif

    iir_cfg_ctrl #(.FLUSH_CYCLES(F)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit_req (commit_req),
        .coef_o     (coef_o),
        .order_o    (order_o),
        .filt_rst_n (filt_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef IIR_CFG_READBACK_EN
        ,
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int exp_done = 0;
    int exp_err  = 0;
    int done_mark;

    logic [559:0] m_coef  = '0;
    logic [3:0]   m_order = 4'd0;
    logic [559:0] q_coef [$];
    logic [3:0]   q_order [$];

    task automatic check(input string tag, input logic [559:0] got, input logic [559:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_wr(input logic [5:0] a, input logic [15:0] d);
        if (a < 6'd35) m_coef[int'(a)*16 +: 16] = d;
        else if (a == 6'd35) m_order = d[3:0];
        else exp_err++;
    endtask

    task automatic write(input logic [5:0] a, input logic [15:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        model_wr(a, d);
    endtask

    task automatic commit(input bit with_wr, input logic [5:0] a, input logic [15:0] d);
        commit_req = 1'b1;
        if (with_wr) begin
            wr_valid = 1'b1;
            wr_addr  = a;
            wr_data  = d;
        end
        @(posedge clk);
        #1;
        commit_req = 1'b0;
        wr_valid   = 1'b0;
        if (with_wr) model_wr(a, d);
        if (m_order == 4'd0 || m_order == 4'd15) begin
            exp_err++;
        end else begin
            q_coef.push_back(m_coef);
            q_order.push_back(m_order);
            exp_done++;
        end
    endtask

    // From T+1 (just after the commit edge) to the first IDLE cycle.
    task automatic wait_idle();
        repeat (F + 1) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (done) begin
                done_cnt++;
                if (q_coef.size() == 0) begin
                    check("done_unexpected", 560'(done), 560'd0);
                end else begin
                    check("sb_coef", coef_o, q_coef.pop_front());
                    check("sb_order", 560'(order_o), 560'(q_order.pop_front()));
                    check("sb_frn_done", 560'(filt_rst_n), 560'd1);
                end
            end
            if (err) err_cnt++;
        end
    end

    initial begin
        #1 reset = 1'b0;
        #1;
        check("rst_wr_ready", 560'(wr_ready), 560'd0);
        check("rst_frn", 560'(filt_rst_n), 560'd0);
        check("rst_busy", 560'(busy), 560'd0);
        check("rst_done", 560'(done), 560'd0);
        check("rst_err", 560'(err), 560'd0);
        check("rst_coef", coef_o, 560'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rel_wr_ready", 560'(wr_ready), 560'd1);
        check("rel_frn", 560'(filt_rst_n), 560'd0);
        check("rel_order", 560'(order_o), 560'd0);
        check("rel_coef", coef_o, 560'd0);

        // Basic commit with cycle-accurate timing
        write(6'd0, 16'h4000);
        write(6'd21, 16'hC000);
        write(6'd35, 16'd2);
        commit(1'b0, 6'd0, 16'd0);
        @(negedge clk);
        check("t1_busy", 560'(busy), 560'd1);
        check("t1_frn", 560'(filt_rst_n), 560'd0);
        check("t1_wr_ready", 560'(wr_ready), 560'd0);
        @(negedge clk);
        check("t2_busy", 560'(busy), 560'd1);
        check("t2_frn", 560'(filt_rst_n), 560'd0);
        check("t2_done", 560'(done), 560'd0);
        @(negedge clk);
        check("t3_done", 560'(done), 560'd1);
        check("t3_b0", 560'(coef_o[15:0]), 560'h4000);
        check("t3_a1", 560'(coef_o[351:336]), 560'hC000);
        check("t3_order", 560'(order_o), 560'd2);
        @(negedge clk);
        check("t4_wr_ready", 560'(wr_ready), 560'd1);
        check("t4_busy", 560'(busy), 560'd0);
        check("t4_frn", 560'(filt_rst_n), 560'd1);

        // Illegal orders 0 and 15 are rejected
        for (int i = 0; i < 2; i++) begin
            write(6'd35, (i == 0) ? 16'd0 : 16'd15);
            commit(1'b0, 6'd0, 16'd0);
            @(negedge clk);
            check("rej_err", 560'(err), 560'd1);
            check("rej_busy", 560'(busy), 560'd0);
            check("rej_order", 560'(order_o), 560'd2);
        end

        // Same-cycle write+commit; write and commit attempted during FLUSH
        write(6'd35, 16'd3);
        done_mark = done_cnt;
        commit(1'b1, 6'd20, 16'h1234);
        wr_valid   = 1'b1;
        wr_addr    = 6'd1;
        wr_data    = 16'hBEEF;
        commit_req = 1'b1;
        @(negedge clk);
        check("fl_wr_ready", 560'(wr_ready), 560'd0);
        @(posedge clk);
        #1;
        wr_valid   = 1'b0;
        commit_req = 1'b0;
        repeat (F) @(posedge clk);
        #1;
        check("b20_same_cycle", 560'(coef_o[335:320]), 560'h1234);
        check("one_done", 560'(done_cnt - done_mark), 560'd1);
        check("idle_after", 560'(wr_ready), 560'd1);

        // Unmapped write, then a commit shows no slot changed
        @(negedge clk);
        write(6'd40, 16'h5555);
        @(negedge clk);
        check("unmapped_err", 560'(err), 560'd1);
        commit(1'b0, 6'd0, 16'd0);
        wait_idle();
        check("slot1_kept", 560'(coef_o[31:16]), 560'd0);

        // Reset during FLUSH aborts the commit
        @(negedge clk);
        commit(1'b0, 6'd0, 16'd0);
        reset = 1'b0;
        void'(q_coef.pop_back());
        void'(q_order.pop_back());
        exp_done--;
        m_coef  = '0;
        m_order = 4'd0;
        #1;
        check("abort_frn", 560'(filt_rst_n), 560'd0);
        check("abort_busy", 560'(busy), 560'd0);
        check("abort_done", 560'(done), 560'd0);
        check("abort_order", 560'(order_o), 560'd0);
        check("abort_coef", coef_o, 560'd0);
        check("abort_wr_ready", 560'(wr_ready), 560'd0);
        repeat (3) @(negedge clk);
        check("abort_hold_done", 560'(done), 560'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("post_frn", 560'(filt_rst_n), 560'd0);
        check("post_wr_ready", 560'(wr_ready), 560'd1);
        check("post_order", 560'(order_o), 560'd0);

`ifdef IIR_CFG_READBACK_EN
        write(6'd35, 16'd7);
        rd_addr = 6'd35;
        @(posedge clk);
        #1;
        check("rd_order", 560'(rd_data), 560'h0007);
        rd_addr = 6'd40;
        @(posedge clk);
        #1;
        check("rd_unmapped", 560'(rd_data), 560'd0);
`endif

        repeat (2) @(negedge clk);
        check("final_done_cnt", 560'(done_cnt), 560'(exp_done));
        check("final_err_cnt", 560'(err_cnt), 560'(exp_err));
        check("final_queue", 560'(q_coef.size()), 560'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
